// File: rtl/bit_deser_if.sv
// Serial-in / word-out bundle for bit_deser.
//   bit_in, bit_valid : serial bit stream from the upstream FSM
//   word_out          : assembled word, first received bit in the MSB
//   word_valid        : word_out holds an unconsumed word
//   word_ready        : consumer accepts word_out on this edge
//   ones_cnt          : number of 1 bits in word_out
//   overflow          : sticky flag, a completed word was dropped
// The master modport is the deserializer; the slave modport is the upstream
// bit source and the downstream word consumer together.
interface bit_deser_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CW-1:0]    ones_cnt;
  logic             overflow;

  modport master (
    input  bit_in,
    input  bit_valid,
    input  word_ready,
    output word_out,
    output word_valid,
    output ones_cnt,
    output overflow
  );

  modport slave (
    output bit_in,
    output bit_valid,
    output word_ready,
    input  word_out,
    input  word_valid,
    input  ones_cnt,
    input  overflow
  );
endinterface

// File: rtl/bit_deser.sv
// Serial-to-parallel word assembler with a one-word output buffer.
//   clk   : single clock, rising-edge
//   reset : synchronous, active-low
//   bus   : bit_deser_if.master (serial input, word handshake, status)
// Bits sampled while bit_valid=1 are assembled MSB-first. The WIDTH-th bit
// completes the word, which is registered together with its popcount and
// presented with word_valid one cycle later. A word completing while the
// previous one is still pending and not being accepted is dropped and the
// sticky overflow flag is raised.
module bit_deser #(
  parameter int unsigned WIDTH = 8
) (
  input logic        clk,
  input logic        reset,
  bit_deser_if.master bus
);

  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StCollect
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Only WIDTH-1 earlier bits need storing: the completing bit comes
  // straight from bit_in.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] assembled;
  logic             complete;
  logic             handshake;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] w);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CW'(w[i]);
    end
    return n;
  endfunction

  assign assembled = {shift_q, bus.bit_in};
  assign handshake = valid_q & bus.word_ready;

  // Collector FSM and output buffer next-state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    word_d   = word_q;
    ones_d   = ones_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    complete = 1'b0;

    if (bus.bit_valid) begin
      shift_d = assembled[WIDTH-2:0];
      unique case (state_q)
        StIdle: begin
          cnt_d   = CntW'(1);
          state_d = StCollect;
        end
        StCollect: begin
          if (cnt_q == LastCnt) begin
            cnt_d    = '0;
            state_d  = StIdle;
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      endcase
    end

    if (complete) begin
      // Load if the buffer is empty or being drained on this same edge.
      if (!valid_q || bus.word_ready) begin
        word_d  = assembled;
        ones_d  = popcount(assembled);
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      ones_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      ones_q  <= ones_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.ones_cnt   = ones_q;
  assign bus.word_valid = valid_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_bit_deser.sv
// Self-checking bench for bit_deser at WIDTH=8: a table of single-word
// vectors plus hand-written overflow, back-to-back and mid-word-reset
// sequences. Words expected to be handed over are queued when their bits
// are driven and compared whenever the DUT completes a handshake.
module tb_bit_deser;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  typedef struct {
    logic [W-1:0]  word;
    logic [CW-1:0] ones;
  } exp_t;

  typedef struct {
    logic [W-1:0]  word;
    bit            gapped;
    logic [W-1:0]  exp_word;
    logic [CW-1:0] exp_ones;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  bit_deser_if #(.WIDTH(W)) ifc ();

  bit_deser #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor: valid and ready are stable at the falling edge, so a
  // handshake happens on the following rising edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && ifc.word_valid === 1'b1 && ifc.word_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)",
                 ifc.word_out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_word", 32'(ifc.word_out), 32'(e.word));
        check("sb_ones", 32'(ifc.ones_cnt), 32'(e.ones));
      end
    end
  end

  // Drives one word MSB-first; optionally with an idle cycle between bits,
  // and optionally checks that no word appears before the last bit.
  task automatic send_word(input logic [W-1:0] w, input bit gapped, input bit chk_early);
    for (int i = W - 1; i >= 0; i--) begin
      if (gapped && i != W - 1) begin
        ifc.bit_valid = 1'b0;
        tick();
      end
      if (chk_early && i == 0) check("no_early_valid", 32'(ifc.word_valid), 32'd0);
      ifc.bit_valid = 1'b1;
      ifc.bit_in    = w[i];
      tick();
    end
    ifc.bit_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{word: 8'hB2, gapped: 1'b0, exp_word: 8'hB2, exp_ones: 4'd4};
    vecs[1] = '{word: 8'hB2, gapped: 1'b1, exp_word: 8'hB2, exp_ones: 4'd4};
    vecs[2] = '{word: 8'h00, gapped: 1'b0, exp_word: 8'h00, exp_ones: 4'd0};
    vecs[3] = '{word: 8'hFF, gapped: 1'b0, exp_word: 8'hFF, exp_ones: 4'd8};
    vecs[4] = '{word: 8'h81, gapped: 1'b1, exp_word: 8'h81, exp_ones: 4'd2};
    vecs[5] = '{word: 8'h3C, gapped: 1'b0, exp_word: 8'h3C, exp_ones: 4'd4};
    vecs[6] = '{word: 8'hA5, gapped: 1'b0, exp_word: 8'hA5, exp_ones: 4'd4};
    vecs[7] = '{word: 8'h01, gapped: 1'b1, exp_word: 8'h01, exp_ones: 4'd1};

    // Reset held two cycles while bits are offered.
    reset          = 1'b0;
    ifc.bit_valid  = 1'b1;
    ifc.bit_in     = 1'b1;
    ifc.word_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(ifc.word_valid), 32'd0);
    check("rst_word", 32'(ifc.word_out), 32'h00);
    check("rst_ones", 32'(ifc.ones_cnt), 32'd0);
    check("rst_ovf", 32'(ifc.overflow), 32'd0);
    ifc.bit_valid = 1'b0;
    reset         = 1'b1;
    tick();

    // Table: single words with the consumer always ready.
    ifc.word_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      sb.push_back('{word: vecs[v].exp_word, ones: vecs[v].exp_ones});
      send_word(vecs[v].word, vecs[v].gapped, 1'b1);
      check("vec_valid_rise", 32'(ifc.word_valid), 32'd1);
      check("vec_word", 32'(ifc.word_out), 32'(vecs[v].exp_word));
      check("vec_ones", 32'(ifc.ones_cnt), 32'(vecs[v].exp_ones));
      tick();
      check("vec_valid_clear", 32'(ifc.word_valid), 32'd0);
      check("vec_ovf", 32'(ifc.overflow), 32'd0);
    end

    // Overflow: second word completes while the first is stalled.
    ifc.word_ready = 1'b0;
    sb.push_back('{word: 8'hFF, ones: 4'd8});
    send_word(8'hFF, 1'b0, 1'b0);
    check("ovf_first_valid", 32'(ifc.word_valid), 32'd1);
    check("ovf_first_flag", 32'(ifc.overflow), 32'd0);
    send_word(8'h0F, 1'b0, 1'b0);
    check("ovf_word_held", 32'(ifc.word_out), 32'hFF);
    check("ovf_ones_held", 32'(ifc.ones_cnt), 32'd8);
    check("ovf_flag", 32'(ifc.overflow), 32'd1);
    check("ovf_valid_held", 32'(ifc.word_valid), 32'd1);
    ifc.word_ready = 1'b1;
    tick();
    check("ovf_drain_valid", 32'(ifc.word_valid), 32'd0);
    check("ovf_sticky", 32'(ifc.overflow), 32'd1);
    tick();
    check("ovf_sticky2", 32'(ifc.overflow), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(ifc.overflow), 32'd0);

    // Back-to-back: 0xA5 pending, handshake on the edge completing 0x3C.
    ifc.word_ready = 1'b0;
    sb.push_back('{word: 8'hA5, ones: 4'd4});
    send_word(8'hA5, 1'b0, 1'b0);
    sb.push_back('{word: 8'h3C, ones: 4'd4});
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 0) ifc.word_ready = 1'b1;
      ifc.bit_valid = 1'b1;
      ifc.bit_in    = 8'h3C >> i;
      tick();
    end
    ifc.bit_valid = 1'b0;
    check("b2b_word", 32'(ifc.word_out), 32'h3C);
    check("b2b_ones", 32'(ifc.ones_cnt), 32'd4);
    check("b2b_valid", 32'(ifc.word_valid), 32'd1);
    check("b2b_ovf", 32'(ifc.overflow), 32'd0);
    tick();
    check("b2b_drained", 32'(ifc.word_valid), 32'd0);

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 5; i++) begin
      ifc.bit_valid = 1'b1;
      ifc.bit_in    = (i % 2 == 0);
      tick();
    end
    ifc.bit_valid = 1'b0;
    do_reset();
    check("mid_rst_valid", 32'(ifc.word_valid), 32'd0);
    sb.push_back('{word: 8'h81, ones: 4'd2});
    send_word(8'h81, 1'b0, 1'b1);
    check("mid_rst_word", 32'(ifc.word_out), 32'h81);
    check("mid_rst_ones", 32'(ifc.ones_cnt), 32'd2);
    check("mid_rst_valid_rise", 32'(ifc.word_valid), 32'd1);

    repeat (4) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_deser.md
BIT_DESER -- requirements
Module: bit_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of serial bits per assembled word (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port bit_in, input, 1 bit: the serial data bit, i.e. the upstream Mealy FSM output.
REQ-005 The block SHALL have port bit_valid, input, 1 bit: bit_in is sampled on any rising edge where bit_valid=1.
REQ-006 The block SHALL have port word_out, output, WIDTH bits: the assembled word.
REQ-007 The block SHALL have port word_valid, output, 1 bit: word_out holds an unconsumed word.
REQ-008 The block SHALL have port word_ready, input, 1 bit: the consumer accepts word_out.
REQ-009 The block SHALL have port ones_cnt, output, CW=$clog2(WIDTH+1) bits: count of 1 bits in word_out.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky word-drop flag.

Function
REQ-011 The collector SHALL be a two-state FSM: IDLE (bit count 0) and COLLECT (bit count 1..WIDTH-1).
REQ-012 A sampled bit SHALL shift into the LSB of a WIDTH-bit shift register, so the first bit received ends in word_out[WIDTH-1] (MSB-first).
REQ-013 From IDLE, a sampled bit SHALL set the count to 1 and move the FSM to COLLECT.
REQ-014 In COLLECT, each sampled bit SHALL increment the count; cycles with bit_valid=0 SHALL hold all collector state.
REQ-015 The edge that samples the WIDTH-th bit SHALL complete the word: the count returns to 0 and the FSM returns to IDLE.
REQ-016 On completion, {shift[WIDTH-2:0], bit_in} SHALL be written to word_out at that same edge.
REQ-017 word_valid SHALL be high in the cycle immediately after the completing cycle, giving a latency of 1 cycle.
REQ-018 ones_cnt SHALL be the popcount of the completed word, registered at the same edge as word_out.
REQ-019 A handshake SHALL occur on an edge where word_valid=1 and word_ready=1; word_valid clears on that edge unless a word completes on the same edge.
REQ-020 While word_valid=1 and word_ready=0, word_out and ones_cnt SHALL hold stable.
REQ-021 The collector SHALL keep accepting bits while word_valid=1, giving one word of buffering.
REQ-022 If a word completes on an edge with a handshake, the new word SHALL load, word_valid SHALL stay 1, and overflow SHALL be unchanged (back-to-back transfer).
REQ-023 If a word completes while word_valid=1 and word_ready=0, the new word SHALL be discarded, the old word_out and ones_cnt held, and overflow set to 1.
REQ-024 Once set, overflow SHALL remain 1 until reset.
REQ-025 word_ready SHALL be ignored while word_valid=0.

Reset
REQ-026 The block SHALL treat reset=0 sampled at a rising edge as a reset; on that edge the FSM goes to IDLE and the count and shift register clear.
REQ-027 The same reset edge SHALL set word_out=0, ones_cnt=0, word_valid=0 and overflow=0.
REQ-028 Reset SHALL take priority over bit_valid and handshake.
REQ-029 A reset mid-word SHALL discard the partial word.
REQ-030 The first bit sampled after reset returns to 1 SHALL be bit 1 of a new word.

Verification (WIDTH=8)
REQ-031 The bench SHALL cover reset: hold reset=0 for 2 cycles with bit_valid=1 -> word_valid=0, word_out=0x00, ones_cnt=0, overflow=0.
REQ-032 The bench SHALL cover a basic word: bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles with word_ready=1 -> next cycle word_valid=1, word_out=0xB2, ones_cnt=4; word_valid clears after 1 cycle.
REQ-033 The bench SHALL cover a gapped stream: the same bits with bit_valid=0 inserted between each -> identical word_out=0xB2, with word_valid rising 1 cycle after the 8th sampled bit.
REQ-034 The bench SHALL cover overflow: word_ready=0, send 0xFF then 0x0F -> word_out stays 0xFF, ones_cnt=8, overflow=1; after word_ready=1, word_valid clears and overflow stays 1.
REQ-035 The bench SHALL cover back-to-back: word 0xA5 pending, word_ready=1 on the edge completing 0x3C -> word_out=0x3C, ones_cnt=4, word_valid stays 1, overflow=0.
REQ-036 The bench SHALL cover reset mid-word: 5 bits, then reset=0 for 1 cycle, then 8 bits of 0x81 -> word_out=0x81, ones_cnt=2, with no earlier word_valid.
